// File: rtl/ofm_write_ctrl_if.sv
// Tile-input and OFM-RAM-write bundle for ofm_write_ctrl.
// The bench drives the master side and the controller takes the slave side.
interface ofm_write_ctrl_if #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 18
);
  logic                                   start;
  logic                                   in_valid;
  logic                                   in_ready;
  logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0]  in_data;
  logic                                   ofm_we;
  logic [ADDR_WIDTH-1:0]                  ofm_addr;
  logic [2*DATA_WIDTH-1:0]                ofm_wdata;
  logic                                   done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, ofm_we, ofm_addr, ofm_wdata, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, ofm_we, ofm_addr, ofm_wdata, done
  );
endinterface

// File: rtl/ofm_write_ctrl.sv
// Unpacks pooled tiles into one OFM RAM word per cycle, walking
// col_tile -> row -> filter, and pulses done after the last word of a layer.
module ofm_write_ctrl #(
  parameter int SYSTOLIC_SIZE    = 16,
  parameter int DATA_WIDTH       = 8,
  parameter int OFM_SIZE_POOLING = 52,
  parameter int NO_FILTER        = 64,
  parameter int ADDR_WIDTH       = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  ofm_write_ctrl_if.slave   bus
);
  localparam int EW         = 2 * DATA_WIDTH;
  localparam int TILES      = (OFM_SIZE_POOLING + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int LAST_LANES = OFM_SIZE_POOLING - (TILES - 1) * SYSTOLIC_SIZE;
  localparam int LANE_W     = (SYSTOLIC_SIZE > 1)    ? $clog2(SYSTOLIC_SIZE)    : 1;
  localparam int COL_W      = (TILES > 1)            ? $clog2(TILES)            : 1;
  localparam int ROW_W      = (OFM_SIZE_POOLING > 1) ? $clog2(OFM_SIZE_POOLING) : 1;
  localparam int FIL_W      = (NO_FILTER > 1)        ? $clog2(NO_FILTER)        : 1;

  typedef enum logic [1:0] {IDLE, WAIT_TILE, WRITE, FINISH} state_t;

  state_t                          state_q, state_d;
  logic [SYSTOLIC_SIZE*EW-1:0]     hold_q, hold_d;
  logic [LANE_W-1:0]               lane_q, lane_d;
  logic [COL_W-1:0]                col_q, col_d;
  logic [ROW_W-1:0]                row_q, row_d;
  logic [FIL_W-1:0]                fil_q, fil_d;
  logic [ADDR_WIDTH-1:0]           last_addr_q, last_addr_d;
  logic [EW-1:0]                   last_data_q, last_data_d;

  logic [EW-1:0]                   hold_lane [SYSTOLIC_SIZE];
  logic                            accept, col_last, row_last, fil_last;
  logic                            lane_last, layer_last;
  logic [LANE_W-1:0]               lane_max;
  logic [ADDR_WIDTH-1:0]           addr_cur;
  logic [EW-1:0]                   wdata_cur;

  for (genvar gi = 0; gi < SYSTOLIC_SIZE; gi++) begin : g_lane
    assign hold_lane[gi] = hold_q[gi*EW +: EW];
  end

  assign accept     = (state_q == WAIT_TILE) && bus.in_valid;
  assign col_last   = (col_q == COL_W'(TILES - 1));
  assign row_last   = (row_q == ROW_W'(OFM_SIZE_POOLING - 1));
  assign fil_last   = (fil_q == FIL_W'(NO_FILTER - 1));
  // The last tile of a row is narrower when the row width is not a tile multiple.
  assign lane_max   = col_last ? LANE_W'(LAST_LANES - 1) : LANE_W'(SYSTOLIC_SIZE - 1);
  assign lane_last  = (lane_q == lane_max);
  assign layer_last = lane_last && col_last && row_last && fil_last;

  assign addr_cur  = ADDR_WIDTH'(fil_q) * ADDR_WIDTH'(OFM_SIZE_POOLING * OFM_SIZE_POOLING)
                   + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(OFM_SIZE_POOLING)
                   + ADDR_WIDTH'(col_q) * ADDR_WIDTH'(SYSTOLIC_SIZE)
                   + ADDR_WIDTH'(lane_q);
  assign wdata_cur = hold_lane[lane_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.start) state_d = WAIT_TILE;
      WAIT_TILE: if (bus.in_valid) state_d = WRITE;
      WRITE:     if (lane_last) state_d = layer_last ? FINISH : WAIT_TILE;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == WAIT_TILE);
    bus.ofm_we    = (state_q == WRITE);
    bus.done      = (state_q == FINISH);
    bus.ofm_addr  = bus.ofm_we ? addr_cur  : last_addr_q;
    bus.ofm_wdata = bus.ofm_we ? wdata_cur : last_data_q;
  end

  always_comb begin
    hold_d      = hold_q;
    lane_d      = lane_q;
    col_d       = col_q;
    row_d       = row_q;
    fil_d       = fil_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (state_q == IDLE && bus.start) begin
      lane_d = '0;
      col_d  = '0;
      row_d  = '0;
      fil_d  = '0;
    end
    if (accept) begin
      hold_d = bus.in_data;
      lane_d = '0;
    end
    if (state_q == WRITE) begin
      last_addr_d = addr_cur;
      last_data_d = wdata_cur;
      if (lane_last) begin
        lane_d = '0;
        if (col_last) begin
          col_d = '0;
          if (row_last) begin
            row_d = '0;
            fil_d = fil_last ? '0 : fil_q + FIL_W'(1);
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      lane_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      fil_q       <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      hold_q      <= hold_d;
      lane_q      <= lane_d;
      col_q       <= col_d;
      row_q       <= row_d;
      fil_q       <= fil_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end
endmodule

// File: tb/tb_ofm_write_ctrl.sv
// Directed bench for ofm_write_ctrl; a reduced filter count keeps the
// full-layer run short while exercising every counter wrap.
module tb_ofm_write_ctrl;
    localparam int SYS = 16;
    localparam int DW  = 8;
    localparam int OFM = 52;
    localparam int NF  = 4;
    localparam int AW  = 18;
    localparam int EW  = 2 * DW;
    localparam int SW  = SYS * EW;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   wr_cnt = 0;

    always #5 clk = ~clk;

    ofm_write_ctrl_if #(.SYSTOLIC_SIZE(SYS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ofm_write_ctrl #(
        .SYSTOLIC_SIZE(SYS), .DATA_WIDTH(DW), .OFM_SIZE_POOLING(OFM),
        .NO_FILTER(NF), .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.ofm_we === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] rand_tile();
        logic [SW-1:0] v;
        for (int k = 0; k < SYS; k++) v[k*EW +: EW] = 16'($urandom);
        return v;
    endfunction

    // Offers one tile in WAIT_TILE and checks every write it produces.
    task automatic run_tile(input logic [SW-1:0] data, input int base, input int n,
                            input bit disturb, input bit last);
        chk("ready_before", bus.in_ready, 1'b1);
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        tick();
        if (!disturb) bus.in_valid = 1'b0;
        bus.in_data = ~data;
        for (int k = 0; k < n; k++) begin
            if (disturb && k == 3) bus.start = 1'b1;
            chk("ready_in_write", bus.in_ready, 1'b0);
            chk("we", bus.ofm_we, 1'b1);
            chk("addr", bus.ofm_addr, AW'(base + k));
            chk("wdata", bus.ofm_wdata, data[k*EW +: EW]);
            tick();
            bus.start = 1'b0;
        end
        chk("we_after", bus.ofm_we, 1'b0);
        chk("addr_hold", bus.ofm_addr, AW'(base + n - 1));
        chk("wdata_hold", bus.ofm_wdata, data[(n-1)*EW +: EW]);
        if (last) begin
            chk("done_pulse", bus.done, 1'b1);
            chk("ready_finish", bus.in_ready, 1'b0);
            tick();
            chk("done_low", bus.done, 1'b0);
            chk("ready_idle", bus.in_ready, 1'b0);
            chk("done_count", done_cnt, 1);
        end else begin
            chk("ready_next", bus.in_ready, 1'b1);
        end
        $display("tile base=%0d lanes=%0d disturb=%0d last=%0d", base, n, disturb, last);
    endtask

    initial begin
        logic [SW-1:0] d;
        int            snap;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();
        chk("rst_ready", bus.in_ready, 1'b0);
        chk("rst_we", bus.ofm_we, 1'b0);
        chk("rst_addr", bus.ofm_addr, 18'd0);
        chk("rst_wdata", bus.ofm_wdata, 16'd0);
        chk("rst_done", bus.done, 1'b0);

        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        chk("idle_ready", bus.in_ready, 1'b0);
        chk("idle_valid_no_we", bus.ofm_we, 1'b0);
        bus.in_valid = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;

        for (int k = 0; k < SYS; k++) d[k*EW +: EW] = 16'(k + 1);
        run_tile(d, 0, SYS, 1'b0, 1'b0);

        for (int g = 0; g < 5; g++) begin
            tick();
            chk("gap_we", bus.ofm_we, 1'b0);
            chk("gap_ready", bus.in_ready, 1'b1);
            chk("gap_addr", bus.ofm_addr, 18'd15);
        end

        run_tile(rand_tile(), 16, SYS, 1'b0, 1'b0);
        run_tile(rand_tile(), 32, SYS, 1'b0, 1'b0);
        for (int k = 0; k < SYS; k++) d[k*EW +: EW] = 16'hAA00 + 16'(k);
        run_tile(d, 48, 4, 1'b0, 1'b0);
        run_tile(rand_tile(), 52, SYS, 1'b1, 1'b0);
        run_tile(rand_tile(), 68, SYS, 1'b0, 1'b0);

        for (int f = 0; f < NF; f++)
            for (int r = 0; r < OFM; r++)
                for (int c = 0; c < 4; c++) begin
                    if (f == 0 && (r == 0 || (r == 1 && c < 2))) continue;
                    run_tile(rand_tile(), f*OFM*OFM + r*OFM + c*SYS, (c == 3) ? 4 : SYS,
                             1'b0, (f == NF-1 && r == OFM-1 && c == 3));
                end

        tick();
        chk("after_layer_ready", bus.in_ready, 1'b0);
        chk("after_layer_done_count", done_cnt, 1);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        d = rand_tile();
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("pre_rst_addr", bus.ofm_addr, AW'(k));
            tick();
        end
        chk("lane7_we", bus.ofm_we, 1'b1);
        snap  = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_we", bus.ofm_we, 1'b0);
        chk("abort_addr", bus.ofm_addr, 18'd0);
        chk("abort_wdata", bus.ofm_wdata, 16'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("no_writes_after_rst", wr_cnt, snap);
        chk("idle_after_rst", bus.in_ready, 1'b0);
        $display("reset abort at lane 7 writes=%0d", wr_cnt);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_tile(rand_tile(), 0, SYS, 1'b0, 1'b0);
        chk("final_done_count", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
